// File: rtl/mem_access_stage.sv
// MEM stage of the RISC-V core: registers the MEM/WB boundary, runs word
// loads/stores over a req/ready handshake and stalls upstream while a data
// memory access is outstanding. Non-memory results pass through in one cycle.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYC = 255   // 0 disables the access timeout
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        stall,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [29:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic [31:0] wb_data,
   output logic        err
);

   // Counter is at least 8 bits and grows if the timeout needs more.
   localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              is_load_q, is_load_d;
   logic [4:0]        rd_q, rd_d;
   logic              rw_q, rw_d;
   logic              dmem_read_q, dmem_read_d;
   logic              dmem_write_q, dmem_write_d;
   logic [29:0]       dmem_addr_q, dmem_addr_d;
   logic [31:0]       dmem_wdata_q, dmem_wdata_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic              wb_reg_write_q, wb_reg_write_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              err_q, err_d;

   logic              mem_op;
   logic              timeout_hit;

   // Byte offset within the word is irrelevant: only word accesses exist.
   logic              unused_addr_lsb;
   assign unused_addr_lsb = ^ex_alu_out[1:0];

   assign mem_op      = ex_mem_read | ex_mem_write;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_VAL);

   // State and output registers; async reset clears everything, dropping any access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         is_load_q      <= 1'b0;
         rd_q           <= '0;
         rw_q           <= 1'b0;
         dmem_read_q    <= 1'b0;
         dmem_write_q   <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= '0;
         wb_reg_write_q <= 1'b0;
         wb_data_q      <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         is_load_q      <= is_load_d;
         rd_q           <= rd_d;
         rw_q           <= rw_d;
         dmem_read_q    <= dmem_read_d;
         dmem_write_q   <= dmem_write_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         wb_valid_q     <= wb_valid_d;
         wb_rd_q        <= wb_rd_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_data_q      <= wb_data_d;
         err_q          <= err_d;
      end
   end

   // Next-state logic: accept/pass-through in IDLE, complete or abort in ACCESS.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      is_load_d      = is_load_q;
      rd_d           = rd_q;
      rw_d           = rw_q;
      dmem_read_d    = dmem_read_q;
      dmem_write_d   = dmem_write_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_wdata_d   = dmem_wdata_q;
      wb_valid_d     = 1'b0;          // WB is a one-cycle pulse per instruction
      wb_rd_d        = wb_rd_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_data_d      = wb_data_q;
      err_d          = err_q;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (mem_op) begin
                  state_d      = ACCESS;
                  cnt_d        = '0;
                  // A write wins over a simultaneous read request.
                  is_load_d    = ex_mem_read & ~ex_mem_write;
                  rd_d         = ex_rd;
                  rw_d         = ex_reg_write;
                  dmem_read_d  = ex_mem_read & ~ex_mem_write;
                  dmem_write_d = ex_mem_write;
                  dmem_addr_d  = ex_alu_out[31:2];
                  dmem_wdata_d = ex_store_data;
               end else begin
                  wb_valid_d     = 1'b1;
                  wb_rd_d        = ex_rd;
                  wb_reg_write_d = ex_reg_write;
                  wb_data_d      = ex_alu_out;
               end
            end
         end
         ACCESS: begin
            // EX inputs are ignored here; upstream is frozen by stall.
            if (dmem_ready) begin
               state_d        = IDLE;
               dmem_read_d    = 1'b0;
               dmem_write_d   = 1'b0;
               wb_valid_d     = 1'b1;
               wb_rd_d        = rd_q;
               wb_reg_write_d = is_load_q & rw_q;
               wb_data_d      = is_load_q ? dmem_rdata : 32'd0;
            end else if (timeout_hit) begin
               state_d        = IDLE;
               dmem_read_d    = 1'b0;
               dmem_write_d   = 1'b0;
               err_d          = 1'b1;
               wb_valid_d     = 1'b1;
               wb_rd_d        = rd_q;
               wb_reg_write_d = 1'b0;
               wb_data_d      = 32'd0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall        = (state_q == ACCESS);
   assign dmem_read    = dmem_read_q;
   assign dmem_write   = dmem_write_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd        = wb_rd_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_data      = wb_data_q;
   assign err          = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT_CYC = 4).
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
   logic [31:0] ex_alu_out, ex_store_data;
   logic [4:0]  ex_rd;
   logic        stall, dmem_read, dmem_write, dmem_ready;
   logic [29:0] dmem_addr;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        wb_valid, wb_reg_write, err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int stall_len;

   mem_access_stage #(.TIMEOUT_CYC(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_alu_out   (ex_alu_out),
      .ex_store_data(ex_store_data),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .stall        (stall),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ready   (dmem_ready),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .wb_data      (wb_data),
      .err          (err)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $display("check %-22s observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic set_ex(input logic v, input logic rd_op, input logic wr_op,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rw);
      ex_valid      = v;
      ex_mem_read   = rd_op;
      ex_mem_write  = wr_op;
      ex_alu_out    = alu;
      ex_store_data = sd;
      ex_rd         = rd;
      ex_reg_write  = rw;
   endtask

   initial begin
      rst_n      = 1'b0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      set_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
      tick();
      tick();
      chk("reset_stall", stall, 0);
      chk("reset_wb_valid", wb_valid, 0);
      rst_n = 1'b1;

      // ALU pass-through
      set_ex(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 5'd5, 1'b1);
      tick();
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_rd", wb_rd, 5);
      chk("alu_wb_data", wb_data, 32'h10);
      chk("alu_wb_rw", wb_reg_write, 1);
      chk("alu_stall", stall, 0);
      ex_valid = 1'b0;
      tick();
      chk("idle_wb_valid", wb_valid, 0);
      chk("idle_wb_rd_hold", wb_rd, 5);

      // Load, ready on the third ACCESS cycle
      set_ex(1'b1, 1'b1, 1'b0, 32'h0000_1004, 32'd0, 5'd7, 1'b1);
      tick();
      chk("ld_stall1", stall, 1);
      chk("ld_dmem_read", dmem_read, 1);
      chk("ld_dmem_write", dmem_write, 0);
      chk("ld_dmem_addr", dmem_addr, 30'h401);
      chk("ld_wb_valid", wb_valid, 0);
      set_ex(1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0, 5'd1, 1'b0);
      tick();
      chk("ld_stall2", stall, 1);
      chk("ld_addr_hold", dmem_addr, 30'h401);
      tick();
      chk("ld_stall3", stall, 1);
      dmem_ready = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_ready = 1'b0;
      chk("ld_stall_done", stall, 0);
      chk("ld_read_drop", dmem_read, 0);
      chk("ld_wb_valid_done", wb_valid, 1);
      chk("ld_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("ld_wb_rw", wb_reg_write, 1);
      chk("ld_wb_rd", wb_rd, 7);

      // Store, ready on the first ACCESS cycle
      set_ex(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_1234, 5'd2, 1'b0);
      tick();
      chk("st_dmem_write", dmem_write, 1);
      chk("st_dmem_wdata", dmem_wdata, 32'h1234);
      chk("st_dmem_addr", dmem_addr, 30'h2);
      chk("st_stall", stall, 1);
      ex_valid   = 1'b0;
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      chk("st_stall_done", stall, 0);
      chk("st_write_drop", dmem_write, 0);
      chk("st_wb_valid", wb_valid, 1);
      chk("st_wb_rw", wb_reg_write, 0);
      chk("st_wb_data", wb_data, 0);

      // Ready arrives in the same cycle the timeout would fire: ready wins
      set_ex(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 5'd4, 1'b1);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("race_stall", stall, 1);
      dmem_ready = 1'b1;
      dmem_rdata = 32'h0000_0055;
      tick();
      dmem_ready = 1'b0;
      chk("race_wb_data", wb_data, 32'h55);
      chk("race_wb_rw", wb_reg_write, 1);
      chk("race_err", err, 0);

      // Timeout; read+write together behaves as a store
      set_ex(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 5'd3, 1'b1);
      tick();
      chk("both_dmem_read", dmem_read, 0);
      chk("both_dmem_write", dmem_write, 1);
      ex_valid  = 1'b0;
      stall_len = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (stall) stall_len++;
         else break;
      end
      chk("to_stall_cycles", stall_len, 5);
      chk("to_err", err, 1);
      chk("to_wb_valid", wb_valid, 1);
      chk("to_wb_rw", wb_reg_write, 0);
      chk("to_wb_data", wb_data, 0);
      chk("to_write_drop", dmem_write, 0);
      set_ex(1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'd0, 5'd9, 1'b1);
      tick();
      chk("post_to_wb_data", wb_data, 32'hABC);
      chk("post_to_wb_rd", wb_rd, 9);
      chk("err_sticky", err, 1);

      // Load followed by an ALU op held in EX across the stall
      set_ex(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'd0, 5'd10, 1'b1);
      tick();
      set_ex(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'd0, 5'd11, 1'b1);
      tick();
      chk("b2b_hold_wb_valid", wb_valid, 0);
      dmem_ready = 1'b1;
      dmem_rdata = 32'h0000_0099;
      tick();
      dmem_ready = 1'b0;
      chk("b2b_ld_wb_rd", wb_rd, 10);
      chk("b2b_ld_wb_data", wb_data, 32'h99);
      tick();
      chk("b2b_alu_wb_valid", wb_valid, 1);
      chk("b2b_alu_wb_rd", wb_rd, 11);
      chk("b2b_alu_wb_data", wb_data, 32'h77);
      ex_valid = 1'b0;
      tick();
      chk("b2b_alu_once", wb_valid, 0);

      // Async reset in the middle of an access, between clock edges
      set_ex(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 5'd12, 1'b1);
      tick();
      ex_valid = 1'b0;
      chk("rst_pre_stall", stall, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_stall", stall, 0);
      chk("rst_async_read", dmem_read, 0);
      chk("rst_async_wb_valid", wb_valid, 0);
      chk("rst_async_err", err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_after_stall", stall, 0);
      chk("rst_after_wb_valid", wb_valid, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
